vga_timing_gen: RTL and testbench

//   Parametrised VGA raster generator: pixel-clock divider, programmable H/V timing and

---
 rtl/vga_timing_gen.sv | 162 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster generator running entirely on CLOCK_50. A divider produces one
//   pix_tick per CLK_DIV cycles plus a square VGA_CLK; horizontal and vertical
//   counters walk the raster (active, front porch, sync, back porch). The drawing
//   logic sees x/y/active and the line/frame strobes. {active, hsync, vsync} then
//   pass through a PIX_LATENCY-deep delay line, so the DAC signals for a pixel
//   appear exactly PIX_LATENCY ticks after its x/y were presented.
// Ports
//   CLOCK_50                 single clock for every register
//   reset                    asynchronous, active-low
//   R, G, B                  renderer colour (COLOR_BITS each), captured each pix_tick
//   VGA_CLK                  pixel clock to the DAC
//   VGA_R/G/B                8-bit DAC colour, zero outside the active area
//   VGA_HS, VGA_VS           syncs, active level set by HS_POL / VS_POL
//   VGA_BLANK_N              low outside the active area
//   VGA_SYNC_N               tied low
//   pix_tick                 one CLOCK_50 cycle high per pixel period
//   active, x, y             current pixel; x/y read 10'h3FF outside the active area
//   line_start, frame_start  high for the whole pixel period of hcount==0 (and vcount==0)
module vga_timing_gen #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter int   CLK_DIV     = 2,
  parameter int   COLOR_BITS  = 2,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   PIX_LATENCY = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [COLOR_BITS-1:0] R,
  input  logic [COLOR_BITS-1:0] G,
  input  logic [COLOR_BITS-1:0] B,
  output logic                  VGA_CLK,
  output logic [7:0]            VGA_R,
  output logic [7:0]            VGA_G,
  output logic [7:0]            VGA_B,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic                  VGA_BLANK_N,
  output logic                  VGA_SYNC_N,
  output logic                  pix_tick,
  output logic                  active,
  output logic [9:0]            x,
  output logic [9:0]            y,
  output logic                  line_start,
  output logic                  frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW    = 12;
  localparam int DW    = $clog2(CLK_DIV);
  localparam int L     = PIX_LATENCY;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0]  divcnt;
  logic [DW-1:0]  divcnt_next;
  logic [CW-1:0]  hcount;
  logic [CW-1:0]  vcount;
  logic [CW-1:0]  h_next;
  logic [CW-1:0]  v_next;
  logic           act_next;
  logic           hs_flag;
  logic           vs_flag;
  logic [3*L-1:0] dl;
  logic [3*L+2:0] chain;
  logic [2:0]     tail_next;

  // Replicate a COLOR_BITS value MSB-first across 8 bits (2'b10 -> 8'hAA).
  function automatic logic [7:0] rep(input logic [COLOR_BITS-1:0] c);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[7-i] = c[COLOR_BITS-1-(i % COLOR_BITS)];
    return r;
  endfunction

  // pix_tick and VGA_CLK are registered from the next divider value so that
  // pix_tick is high exactly while divcnt==CLK_DIV-1 and serves as the enable.
  assign divcnt_next = (divcnt == DIV_LAST) ? '0 : divcnt + DW'(1);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      divcnt   <= '0;
      pix_tick <= 1'b0;
      VGA_CLK  <= 1'b0;
    end else begin
      divcnt   <= divcnt_next;
      pix_tick <= (divcnt_next == DIV_LAST);
      VGA_CLK  <= (divcnt_next >= DIV_HALF);
    end
  end

  always_comb begin
    h_next   = (hcount == H_LAST) ? '0 : hcount + CW'(1);
    v_next   = vcount;
    if (hcount == H_LAST) v_next = (vcount == V_LAST) ? '0 : vcount + CW'(1);
    act_next = (h_next < H_ACT) && (v_next < V_ACT);
  end

  // Delay-line head is the registered {active, hs, vs} of the current pixel;
  // tail_next is what the last stage takes on this tick, used to gate colour.
  assign chain     = {dl, active, hs_flag, vs_flag};
  assign tail_next = chain[3*L-1 -: 3];

  // Counters start at the last raster position so the first tick lands on (0,0).
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      active      <= 1'b0;
      x           <= 10'h3FF;
      y           <= 10'h3FF;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_flag     <= 1'b0;
      vs_flag     <= 1'b0;
      dl          <= '0;
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
    end else if (pix_tick) begin
      hcount      <= h_next;
      vcount      <= v_next;
      active      <= act_next;
      x           <= act_next ? h_next[9:0] : 10'h3FF;
      y           <= act_next ? v_next[9:0] : 10'h3FF;
      line_start  <= (h_next == '0);
      frame_start <= (h_next == '0) && (v_next == '0);
      hs_flag     <= (h_next >= HS_BEG) && (h_next < HS_END);
      vs_flag     <= (v_next >= VS_BEG) && (v_next < VS_END);
      dl          <= chain[3*L-1:0];
      VGA_R       <= tail_next[2] ? rep(R) : 8'h00;
      VGA_G       <= tail_next[2] ? rep(G) : 8'h00;
      VGA_B       <= tail_next[2] ? rep(B) : 8'h00;
    end
  end

  // Delay-line flags hold "in sync" rather than pin levels, so a cleared line
  // naturally reads as syncs inactive and blanked.
  assign VGA_BLANK_N = dl[3*L-1];
  assign VGA_HS      = dl[3*L-2] ? HS_POL : ~HS_POL;
  assign VGA_VS      = dl[3*L-3] ? VS_POL : ~VS_POL;
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Two instances: dut_a with the default 640x480 timing, dut_b a tiny raster
//   (16x8 totals, CLK_DIV=4, HS_POL=1, PIX_LATENCY=3) so whole frames fit in a
//   short run. dut_b raster positions are checked from a hand-computed table.
module tb_vga_timing_gen;

  logic       clock;
  logic       rst_a, rst_b;
  logic [1:0] r_a, g_a, b_a, r_b, g_b, b_b;

  logic       vclk_a, hs_a, vs_a, blank_a, syncn_a, tick_a, act_a, line_a, frame_a;
  logic [7:0] vr_a, vg_a, vb_a;
  logic [9:0] x_a, y_a;
  logic       vclk_b, hs_b, vs_b, blank_b, syncn_b, tick_b, act_b, line_b, frame_b;
  logic [7:0] vr_b, vg_b, vb_b;
  logic [9:0] x_b, y_b;

  int passed = 0;
  int total  = 0;

  vga_timing_gen dut_a (
    .CLOCK_50(clock), .reset(rst_a), .R(r_a), .G(g_a), .B(b_a),
    .VGA_CLK(vclk_a), .VGA_R(vr_a), .VGA_G(vg_a), .VGA_B(vb_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(blank_a), .VGA_SYNC_N(syncn_a),
    .pix_tick(tick_a), .active(act_a), .x(x_a), .y(y_a),
    .line_start(line_a), .frame_start(frame_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(4), .COLOR_BITS(2), .HS_POL(1'b1), .VS_POL(1'b0), .PIX_LATENCY(3)
  ) dut_b (
    .CLOCK_50(clock), .reset(rst_b), .R(r_b), .G(g_b), .B(b_b),
    .VGA_CLK(vclk_b), .VGA_R(vr_b), .VGA_G(vg_b), .VGA_B(vb_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(blank_b), .VGA_SYNC_N(syncn_b),
    .pix_tick(tick_b), .active(act_b), .x(x_b), .y(y_b),
    .line_start(line_b), .frame_start(frame_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         n;
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       line;
    logic       frame;
    logic       hs;
    logic       vs;
    logic       blank;
  } vec_t;

  vec_t       tbl [16];
  logic [9:0] xh  [0:128];
  logic       ah  [0:128];
  int         n_b;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Advance the selected DUT by one pixel tick; leaves time #1 after that edge.
  task automatic step_tick(input bit use_b);
    int guard;
    guard = 0;
    while ((use_b ? tick_b : tick_a) !== 1'b1 && guard < 16) begin
      @(posedge clock); #1;
      guard++;
    end
    if (guard >= 16) begin
      total++;
      $display("[TB] FAIL tick_timeout: got no pix_tick, expected one within 16 cycles");
    end
    @(posedge clock); #1;
  endtask

  // One dut_b tick; the renderer model returns colour x[1:0] two ticks late,
  // which together with the capture tick makes the 3-tick latency.
  task automatic apply_stimulus();
    step_tick(1'b1);
    n_b++;
    xh[n_b] = x_b;
    ah[n_b] = act_b;
    r_b = (n_b >= 2) ? xh[n_b-2][1:0] : 2'b00;
  endtask

  task automatic check_reset_a(input string tag);
    check_output({tag, "_x"},       32'(x_a),     32'h3FF);
    check_output({tag, "_y"},       32'(y_a),     32'h3FF);
    check_output({tag, "_active"},  32'(act_a),   32'd0);
    check_output({tag, "_line"},    32'(line_a),  32'd0);
    check_output({tag, "_frame"},   32'(frame_a), 32'd0);
    check_output({tag, "_tick"},    32'(tick_a),  32'd0);
    check_output({tag, "_vclk"},    32'(vclk_a),  32'd0);
    check_output({tag, "_hs"},      32'(hs_a),    32'd1);
    check_output({tag, "_vs"},      32'(vs_a),    32'd1);
    check_output({tag, "_blank_n"}, 32'(blank_a), 32'd0);
    check_output({tag, "_vga_r"},   32'(vr_a),    32'd0);
    check_output({tag, "_sync_n"},  32'(syncn_a), 32'd0);
  endtask

  initial begin
    int first_hs, hs_lows, first_blank, first_line, guard;
    int act_cnt, vs_low_cnt, frame_cnt, idx;
    logic [7:0] exp_r;

    //            n    x       y       act line frm hs vs blank
    tbl[0]  = '{  0, 10'h000, 10'h000, 1, 1, 1, 0, 1, 0};
    tbl[1]  = '{  1, 10'h001, 10'h000, 1, 0, 0, 0, 1, 0};
    tbl[2]  = '{  3, 10'h003, 10'h000, 1, 0, 0, 0, 1, 1};
    tbl[3]  = '{  7, 10'h007, 10'h000, 1, 0, 0, 0, 1, 1};
    tbl[4]  = '{  8, 10'h3FF, 10'h3FF, 0, 0, 0, 0, 1, 1};
    tbl[5]  = '{ 11, 10'h3FF, 10'h3FF, 0, 0, 0, 0, 1, 0};
    tbl[6]  = '{ 13, 10'h3FF, 10'h3FF, 0, 0, 0, 1, 1, 0};
    tbl[7]  = '{ 15, 10'h3FF, 10'h3FF, 0, 0, 0, 1, 1, 0};
    tbl[8]  = '{ 16, 10'h000, 10'h001, 1, 1, 0, 0, 1, 0};
    tbl[9]  = '{ 19, 10'h003, 10'h001, 1, 0, 0, 0, 1, 1};
    tbl[10] = '{ 64, 10'h3FF, 10'h3FF, 0, 1, 0, 0, 1, 0};
    tbl[11] = '{ 83, 10'h3FF, 10'h3FF, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{ 90, 10'h3FF, 10'h3FF, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{112, 10'h3FF, 10'h3FF, 0, 1, 0, 0, 0, 0};
    tbl[14] = '{115, 10'h3FF, 10'h3FF, 0, 0, 0, 0, 1, 0};
    tbl[15] = '{128, 10'h000, 10'h000, 1, 1, 1, 0, 1, 0};

    clock = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    r_a = 2'b11; g_a = 2'b10; b_a = 2'b01;
    r_b = 2'b00; g_b = 2'b01; b_b = 2'b10;
    #12;
    check_reset_a("rst_a");
    check_output("rst_b_hs",   32'(hs_b),    32'd0);
    check_output("rst_b_vs",   32'(vs_b),    32'd1);
    check_output("rst_b_x",    32'(x_b),     32'h3FF);
    check_output("rst_b_sync", 32'(syncn_b), 32'd0);

    // Release dut_a: tick after cycle 1, frame start after cycle 2.
    @(negedge clock); rst_a = 1'b1;
    @(posedge clock); #1;
    check_output("c1_tick",  32'(tick_a),  32'd1);
    check_output("c1_vclk",  32'(vclk_a),  32'd1);
    check_output("c1_frame", 32'(frame_a), 32'd0);
    @(posedge clock); #1;
    check_output("c2_frame",  32'(frame_a), 32'd1);
    check_output("c2_line",   32'(line_a),  32'd1);
    check_output("c2_x",      32'(x_a),     32'd0);
    check_output("c2_y",      32'(y_a),     32'd0);
    check_output("c2_active", 32'(act_a),   32'd1);
    check_output("c2_tick",   32'(tick_a),  32'd0);
    check_output("c2_vclk",   32'(vclk_a),  32'd0);
    @(posedge clock); #1;
    check_output("c3_tick",   32'(tick_a),  32'd1);
    @(posedge clock); #1;
    check_output("c4_x",       32'(x_a),     32'd1);
    check_output("c4_frame",   32'(frame_a), 32'd0);
    check_output("c4_blank_n", 32'(blank_a), 32'd1);
    check_output("c4_vga_r",   32'(vr_a),    32'hFF);
    check_output("c4_vga_g",   32'(vg_a),    32'hAA);
    check_output("c4_vga_b",   32'(vb_a),    32'h55);

    // One full default line.
    first_hs = -1; hs_lows = 0; first_blank = -1; first_line = -1;
    for (int n = 2; n <= 800; n++) begin
      step_tick(1'b0);
      if (hs_a == 1'b0) begin
        if (first_hs < 0) first_hs = n;
        hs_lows++;
      end
      if (!blank_a && first_blank < 0) first_blank = n;
      if (line_a && first_line < 0) first_line = n;
    end
    check_output("line_hs_first_low", 32'(first_hs),    32'd657);
    check_output("line_hs_low_ticks", 32'(hs_lows),     32'd96);
    check_output("line_blank_first",  32'(first_blank), 32'd641);
    check_output("line_start_period", 32'(first_line),  32'd800);
    check_output("line1_y",           32'(y_a),         32'd1);
    check_output("line1_x",           32'(x_a),         32'd0);

    // Mid-line asynchronous reset at x=300.
    guard = 0;
    while (x_a !== 10'd300 && guard < 1000) begin
      step_tick(1'b0);
      guard++;
    end
    check_output("mid_reach_x300", 32'(x_a), 32'd300);
    check_output("mid_pre_vga_r",  32'(vr_a), 32'hFF);
    rst_a = 1'b0;
    #1;
    check_reset_a("mid_rst");
    repeat (3) @(posedge clock);
    @(negedge clock); rst_a = 1'b1;
    @(posedge clock); #1;
    check_output("mid_c1_frame", 32'(frame_a), 32'd0);
    @(posedge clock); #1;
    check_output("mid_c2_frame", 32'(frame_a), 32'd1);
    check_output("mid_c2_x",     32'(x_a),     32'd0);
    check_output("mid_c2_y",     32'(y_a),     32'd0);

    // dut_b: divider shape, then a full frame against the table and scoreboard.
    @(negedge clock); rst_b = 1'b1;
    @(posedge clock); #1;
    check_output("b_c1_vclk", 32'(vclk_b), 32'd0);
    check_output("b_c1_tick", 32'(tick_b), 32'd0);
    @(posedge clock); #1;
    check_output("b_c2_vclk", 32'(vclk_b), 32'd1);
    check_output("b_c2_tick", 32'(tick_b), 32'd0);
    @(posedge clock); #1;
    check_output("b_c3_vclk", 32'(vclk_b), 32'd1);
    check_output("b_c3_tick", 32'(tick_b), 32'd1);
    @(posedge clock); #1;
    check_output("b_c4_vclk", 32'(vclk_b), 32'd0);
    check_output("b_c4_tick", 32'(tick_b), 32'd0);

    n_b = 0;
    xh[0] = x_b;
    ah[0] = act_b;
    act_cnt = 0; vs_low_cnt = 0; frame_cnt = 0; idx = 0;
    for (int n = 0; n <= 128; n++) begin
      if (n > 0) begin
        apply_stimulus();
        exp_r = (n >= 3 && ah[n-3]) ? {4{xh[n-3][1:0]}} : 8'h00;
        check_output($sformatf("b_vga_r_n%0d", n), 32'(vr_b), 32'(exp_r));
        check_output($sformatf("b_vga_g_n%0d", n), 32'(vg_b), (n >= 3 && ah[n-3]) ? 32'h55 : 32'h00);
        check_output($sformatf("b_vga_b_n%0d", n), 32'(vb_b), (n >= 3 && ah[n-3]) ? 32'hAA : 32'h00);
        check_output($sformatf("b_blank_n%0d", n), 32'(blank_b), (n >= 3) ? 32'(ah[n-3]) : 32'd0);
        if (vs_b == 1'b0) vs_low_cnt++;
        if (frame_b) frame_cnt++;
      end
      if (n < 128 && act_b) act_cnt++;
      if (idx < 16 && tbl[idx].n == n) begin
        check_output($sformatf("tbl%0d_x", n),     32'(x_b),     32'(tbl[idx].x));
        check_output($sformatf("tbl%0d_y", n),     32'(y_b),     32'(tbl[idx].y));
        check_output($sformatf("tbl%0d_act", n),   32'(act_b),   32'(tbl[idx].act));
        check_output($sformatf("tbl%0d_line", n),  32'(line_b),  32'(tbl[idx].line));
        check_output($sformatf("tbl%0d_frame", n), 32'(frame_b), 32'(tbl[idx].frame));
        check_output($sformatf("tbl%0d_hs", n),    32'(hs_b),    32'(tbl[idx].hs));
        check_output($sformatf("tbl%0d_vs", n),    32'(vs_b),    32'(tbl[idx].vs));
        check_output($sformatf("tbl%0d_blank", n), 32'(blank_b), 32'(tbl[idx].blank));
        idx++;
      end
    end
    check_output("b_table_consumed",  32'(idx),        32'd16);
    check_output("b_active_per_frame", 32'(act_cnt),   32'd32);
    check_output("b_vs_low_ticks",    32'(vs_low_cnt), 32'd32);
    check_output("b_frame_strobes",   32'(frame_cnt),  32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
